// File: rtl/branch_history_predict_pkg.sv
// Shared opcode definitions for the branch history predictor.
// Holds the instruction-class enum, MIPS opcode constants used by the
// fetch-stage decoder, and the counter reset-value helper.
package branch_history_predict_pkg;

  typedef enum logic [1:0] {
    CLS_JUMP   = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_OTHER  = 2'd2
  } instr_class_e;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  // Weakly-not-taken: one below the midpoint (01 for a 2-bit counter).
  function automatic int unsigned ctr_reset_value(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_history_predict_bht_table.sv
// bht_table: array of saturating direction counters.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   rd_idx/rd_cnt  - asynchronous lookup port
//   wr_en, wr_idx, wr_taken - saturating increment (taken) / decrement
// Optional feature: BHT_BYPASS_EN forwards a same-cycle same-index update
// to the read port.
module bht_table
  import branch_history_predict_pkg::*;
#(
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_BITS-1:0]   rd_idx,
  output logic [COUNTER_BITS-1:0] rd_cnt,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_idx,
  input  logic                    wr_taken
);

  localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CNT_RST = COUNTER_BITS'(ctr_reset_value(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

  logic [COUNTER_BITS-1:0] cnt [ENTRIES];
  logic [COUNTER_BITS-1:0] wr_cur;
  logic [COUNTER_BITS-1:0] wr_next;

  always_comb begin
    wr_cur  = cnt[wr_idx];
    wr_next = wr_cur;
    if (wr_taken) begin
      if (wr_cur != '1) wr_next = wr_cur + CNT_ONE;
    end else begin
      if (wr_cur != '0) wr_next = wr_cur - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RST;
    end else if (wr_en) begin
      cnt[wr_idx] <= wr_next;
    end
  end

`ifdef BHT_BYPASS_EN
  // Forwarding is suppressed while reset is low so the lookup shows the
  // reset value rather than an update that will be discarded.
  always_comb begin
    rd_cnt = cnt[rd_idx];
    if (reset && wr_en && (wr_idx == rd_idx)) rd_cnt = wr_next;
  end
`else
  always_comb begin
    rd_cnt = cnt[rd_idx];
  end
`endif

endmodule

// File: rtl/branch_history_predict.sv
// branch_history_predict: fetch-stage branch predictor with a bimodal BHT.
// Ports:
//   clk, reset (async active-low), en (gates all state updates)
//   cur_pc, cur_instr           - instruction being predicted
//   update_valid/pc/taken       - resolved-branch training
//   miss                        - misprediction pulse for statistics
//   pred_pc, pred_taken         - combinational prediction
//   miss_count                  - saturating misprediction count
// Optional feature: BHT_BYPASS_EN (same-cycle update forwarding in bht_table).
module branch_history_predict
  import branch_history_predict_pkg::*;
#(
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned COUNTER_BITS = 2,
  parameter int unsigned STAT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [31:0]          cur_pc,
  input  logic [31:0]          cur_instr,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic                 update_taken,
  input  logic                 miss,
  output logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [STAT_BITS-1:0] miss_count
);

  localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

  logic [COUNTER_BITS-1:0] rd_cnt;
  logic [31:0]             pc_plus4;
  logic [31:0]             jump_target;
  logic [31:0]             branch_target;
  logic [5:0]              opcode;
  instr_class_e            instr_class;
  logic                    unused_update_pc_bits;

  assign unused_update_pc_bits = ^{update_pc[31:INDEX_BITS+2], update_pc[1:0]};

  bht_table #(
    .INDEX_BITS   (INDEX_BITS),
    .COUNTER_BITS (COUNTER_BITS)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (cur_pc[INDEX_BITS+1:2]),
    .rd_cnt   (rd_cnt),
    .wr_en    (en && update_valid),
    .wr_idx   (update_pc[INDEX_BITS+1:2]),
    .wr_taken (update_taken)
  );

  always_comb begin
    opcode        = cur_instr[31:26];
    pc_plus4      = cur_pc + 32'd4;
    jump_target   = {pc_plus4[31:28], cur_instr[25:0], 2'b00};
    branch_target = pc_plus4 + {{14{cur_instr[15]}}, cur_instr[15:0], 2'b00};

    case (opcode)
      OP_J, OP_JAL:                                   instr_class = CLS_JUMP;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:    instr_class = CLS_BRANCH;
      default:                                        instr_class = CLS_OTHER;
    endcase

    pred_taken = 1'b0;
    pred_pc    = pc_plus4;
    case (instr_class)
      CLS_JUMP: begin
        pred_taken = 1'b1;
        pred_pc    = jump_target;
      end
      CLS_BRANCH: begin
        pred_taken = rd_cnt[COUNTER_BITS-1];
        pred_pc    = rd_cnt[COUNTER_BITS-1] ? branch_target : pc_plus4;
      end
      default: begin
        pred_taken = 1'b0;
        pred_pc    = pc_plus4;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_count <= '0;
    end else if (en && miss && (miss_count != '1)) begin
      miss_count <= miss_count + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_history_predict.sv
module tb_branch_history_predict;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        miss;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [3:0]  miss_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_BEQ    = 32'h1000_0004;  // BEQ imm=4
  localparam logic [31:0] I_BNE    = 32'h1400_FFFE;  // BNE imm=-2
  localparam logic [31:0] I_REGIMM = 32'h0401_0003;  // BGEZ imm=3
  localparam logic [31:0] I_J      = 32'h0800_0010;  // J index 0x10
  localparam logic [31:0] I_JAL    = 32'h0FFF_FFFF;  // JAL index all ones
  localparam logic [31:0] I_ADD    = 32'h0000_0020;

`ifdef BHT_BYPASS_EN
  localparam logic BYP_EXP = 1'b1;
`else
  localparam logic BYP_EXP = 1'b0;
`endif

  branch_history_predict #(
    .INDEX_BITS   (6),
    .COUNTER_BITS (2),
    .STAT_BITS    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cur_pc       (cur_pc),
    .cur_instr    (cur_instr),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .miss         (miss),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; miss = 1'b0; cur_pc = 32'h100; cur_instr = I_BEQ;
    #2;
    check("rst_miss_count", {28'b0, miss_count}, 32'd0);
    check("rst_beq_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_beq_pc", pred_pc, 32'h104);
    step(); step();
    reset = 1'b1; en = 1'b1;
    #1;
    check("post_rst_beq_taken", {31'b0, pred_taken}, 32'd0);

    // Training at 0x100: 1 -> 2 -> 3 -> 3 (saturate) -> 2 -> 1
    update_pc = 32'h100; update_taken = 1'b1; update_valid = 1'b1;
    step(); update_valid = 1'b0; #1;
    check("train1_taken", {31'b0, pred_taken}, 32'd1);
    check("train1_pc", pred_pc, 32'h114);
    update_valid = 1'b1;
    step(); update_valid = 1'b0; #1;
    check("train2_taken", {31'b0, pred_taken}, 32'd1);
    check("train2_pc", pred_pc, 32'h114);
    update_valid = 1'b1;
    step();
    update_taken = 1'b0;
    step(); update_valid = 1'b0; #1;
    check("sat_dec1_taken", {31'b0, pred_taken}, 32'd1);
    update_valid = 1'b1;
    step(); update_valid = 1'b0; #1;
    check("sat_dec2_taken", {31'b0, pred_taken}, 32'd0);
    check("sat_dec2_pc", pred_pc, 32'h104);

    // Jumps ignore the BHT
    cur_pc = 32'h0040_0000; cur_instr = I_J; #1;
    check("j_pc", pred_pc, 32'h0000_0040);
    check("j_taken", {31'b0, pred_taken}, 32'd1);
    cur_pc = 32'hF000_0000; cur_instr = I_JAL; #1;
    check("jal_pc", pred_pc, 32'hFFFF_FFFC);
    check("jal_taken", {31'b0, pred_taken}, 32'd1);

    // Non-branch, including PC wrap
    cur_pc = 32'h100; cur_instr = I_ADD; #1;
    check("other_taken", {31'b0, pred_taken}, 32'd0);
    check("other_pc", pred_pc, 32'h104);
    cur_pc = 32'hFFFF_FFFC; #1;
    check("other_wrap_pc", pred_pc, 32'h0);

    // Backward BNE at 0x200 shares index 0 (counter 1)
    cur_pc = 32'h200; cur_instr = I_BNE; #1;
    check("bne_nt_pc", pred_pc, 32'h204);
    update_pc = 32'h200; update_taken = 1'b1; update_valid = 1'b1;
    step(); update_valid = 1'b0; #1;
    check("bne_t_taken", {31'b0, pred_taken}, 32'd1);
    check("bne_t_pc", pred_pc, 32'h1FC);

    // REGIMM at 0x104 (index 1, untouched)
    cur_pc = 32'h104; cur_instr = I_REGIMM; #1;
    check("regimm_taken", {31'b0, pred_taken}, 32'd0);
    check("regimm_pc", pred_pc, 32'h108);

    // Same-cycle update and lookup with counter=1 at 0x100
    update_pc = 32'h100; update_taken = 1'b0; update_valid = 1'b1;
    step();
    cur_pc = 32'h100; cur_instr = I_BEQ; update_taken = 1'b1; #1;
    check("same_cycle_taken", {31'b0, pred_taken}, {31'b0, BYP_EXP});
    step(); update_valid = 1'b0; #1;
    check("after_same_cycle_taken", {31'b0, pred_taken}, 32'd1);

    // en=0 holds all state
    en = 1'b0; update_pc = 32'h104; update_taken = 1'b1; update_valid = 1'b1; miss = 1'b1;
    cur_pc = 32'h104; cur_instr = I_REGIMM;
    step(); step(); step();
    check("hold_taken", {31'b0, pred_taken}, 32'd0);
    check("hold_miss_count", {28'b0, miss_count}, 32'd0);

    // Update and miss together
    en = 1'b1;
    step(); update_valid = 1'b0; miss = 1'b0; #1;
    check("concur_miss_count", {28'b0, miss_count}, 32'd1);
    check("concur_taken", {31'b0, pred_taken}, 32'd1);
    check("concur_pc", pred_pc, 32'h114);

    // Miss counter saturation at 15
    miss = 1'b1;
    for (int i = 0; i < 13; i++) step();
    miss = 1'b0; #1;
    check("miss_count_14", {28'b0, miss_count}, 32'd14);
    miss = 1'b1;
    for (int i = 0; i < 6; i++) step();
    miss = 1'b0; #1;
    check("miss_count_sat", {28'b0, miss_count}, 32'd15);

    // Reset mid-stream with an update pending
    cur_pc = 32'h100; cur_instr = I_BEQ;
    update_pc = 32'h100; update_taken = 1'b1; update_valid = 1'b1; miss = 1'b1;
    #1 reset = 1'b0; #1;
    check("midrst_miss_count", {28'b0, miss_count}, 32'd0);
    check("midrst_beq_taken", {31'b0, pred_taken}, 32'd0);
    check("midrst_beq_pc", pred_pc, 32'h104);
    cur_pc = 32'h104; cur_instr = I_REGIMM; #1;
    check("midrst_regimm_taken", {31'b0, pred_taken}, 32'd0);
    step();
    reset = 1'b1; update_valid = 1'b0; miss = 1'b0;
    cur_pc = 32'h100; cur_instr = I_BEQ; #1;
    check("postrst_beq_taken", {31'b0, pred_taken}, 32'd0);
    step();
    check("postrst_hold_taken", {31'b0, pred_taken}, 32'd0);
    check("postrst_miss_count", {28'b0, miss_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
